// File: rtl/decoder_scan_n_if.sv
// Control/observation bundle for decoder_scan_n: drive-side inputs and registered line outputs.
interface decoder_scan_n_if #(parameter int SEL_W = 2);
  logic                  en;
  logic                  mode;
  logic                  dir;
  logic [SEL_W-1:0]      sel;
  logic [(1<<SEL_W)-1:0] o;
  logic [SEL_W-1:0]      idx;
  logic                  wrap;

  modport master (output en, mode, dir, sel, input o, idx, wrap);
  modport slave  (input en, mode, dir, sel, output o, idx, wrap);
endinterface

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N line decoder with enable, selectable polarity and an
// autonomous rotating scan mode.
module decoder_scan_n #(
  parameter int SEL_W      = 2,
  parameter int SCAN_DIV   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input logic           clk,
  input logic           rst_n,
  decoder_scan_n_if.slave bus
);
  localparam int NL    = 1 << SEL_W;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic             INACT   = (ACTIVE_LOW != 0);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_step;
  logic [NL-1:0]    o_q;
  logic             wrap_q;

  function automatic logic [NL-1:0] line(input logic [SEL_W-1:0] s);
    logic [NL-1:0] l;
    l    = {NL{INACT}};
    l[s] = ~INACT;
    return l;
  endfunction

  // Direction is sampled at the step itself, so a mid-scan dir change takes
  // effect on the next step without disturbing the divider.
  assign idx_step = bus.dir ? idx_q - SEL_W'(1) : idx_q + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      o_q     <= {NL{INACT}};
      wrap_q  <= 1'b0;
    end else if (!bus.en) begin
      state_q <= IDLE;
      div_q   <= '0;
      o_q     <= {NL{INACT}};
      wrap_q  <= 1'b0;
    end else if (!bus.mode) begin
      state_q <= DECODE;
      div_q   <= '0;
      idx_q   <= bus.sel;
      o_q     <= line(bus.sel);
      wrap_q  <= 1'b0;
    end else begin
      state_q <= SCAN;
      if (state_q != SCAN) begin
        div_q  <= '0;
        idx_q  <= bus.sel;
        o_q    <= line(bus.sel);
        wrap_q <= 1'b0;
      end else if (div_q == DIV_MAX) begin
        div_q  <= '0;
        idx_q  <= idx_step;
        o_q    <= line(idx_step);
        wrap_q <= bus.dir ? (idx_q == '0) : (idx_q == IDX_MAX);
      end else begin
        div_q  <= div_q + DIV_W'(1);
        wrap_q <= 1'b0;
      end
    end
  end

  assign bus.o    = o_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n: reset, decode sweeps in both polarities,
// scan up/down with wrap, enable/mode changes and mid-scan reset.
module tb_decoder_scan_n;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_tot;

  decoder_scan_n_if #(.SEL_W(2)) b0 ();
  decoder_scan_n_if #(.SEL_W(3)) b1 ();
  decoder_scan_n_if #(.SEL_W(3)) b2 ();
  decoder_scan_n_if #(.SEL_W(2)) b3 ();

  decoder_scan_n #(.SEL_W(2), .SCAN_DIV(4), .ACTIVE_LOW(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  decoder_scan_n #(.SEL_W(3), .SCAN_DIV(4), .ACTIVE_LOW(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  decoder_scan_n #(.SEL_W(3), .SCAN_DIV(4), .ACTIVE_LOW(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  decoder_scan_n #(.SEL_W(2), .SCAN_DIV(1), .ACTIVE_LOW(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic [7:0] e8;
    int idx_seq [8]  = '{1, 0, 3, 2, 1, 0, 3, 2};
    int wrap_seq [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    n_pass = 0;
    n_tot  = 0;

    rst_n = 1'b0;
    b0.en = 1'b1; b0.mode = 1'b0; b0.dir = 1'b0; b0.sel = 2'd2;
    b1.en = 1'b0; b1.mode = 1'b0; b1.dir = 1'b0; b1.sel = '0;
    b2.en = 1'b0; b2.mode = 1'b0; b2.dir = 1'b0; b2.sel = '0;
    b3.en = 1'b0; b3.mode = 1'b0; b3.dir = 1'b0; b3.sel = '0;

    // Reset held for three edges
    repeat (3) step();
    chk("rst_o",      32'(b0.o),    32'h0);
    chk("rst_idx",    32'(b0.idx),  32'h0);
    chk("rst_wrap",   32'(b0.wrap), 32'h0);
    chk("rst_o_al",   32'(b2.o),    32'hFF);
    rst_n = 1'b1;
    step();
    chk("post_rst_o",   32'(b0.o),   32'h4);
    chk("post_rst_idx", 32'(b0.idx), 32'h2);

    // Decode sweep, both polarities
    b1.en = 1'b1; b2.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b1.sel = 3'(i); b2.sel = 3'(i);
      step();
      e8 = 8'd1 << i;
      chk("dec_o",    32'(b1.o),   32'(e8));
      chk("dec_idx",  32'(b1.idx), 32'(i));
      e8 = ~e8;
      chk("dec_o_al", 32'(b2.o),   32'(e8));
    end
    b1.en = 1'b0; b2.en = 1'b0;
    step();
    chk("idle_o",     32'(b1.o),   32'h0);
    chk("idle_idx",   32'(b1.idx), 32'h7);
    chk("idle_o_al",  32'(b2.o),   32'hFF);

    // Scan up from 3, dwell 4
    b0.sel = 2'd3; b0.mode = 1'b1; b0.dir = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("up_dwell3_o",    32'(b0.o),    32'h8);
      chk("up_dwell3_wrap", 32'(b0.wrap), 32'h0);
    end
    step();
    chk("up_wrap_o",   32'(b0.o),    32'h1);
    chk("up_wrap_idx", 32'(b0.idx),  32'h0);
    chk("up_wrap",     32'(b0.wrap), 32'h1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("up_dwell0_o",    32'(b0.o),    32'h1);
      chk("up_dwell0_wrap", 32'(b0.wrap), 32'h0);
    end
    step();
    chk("up_step1_o", 32'(b0.o), 32'h2);
    b0.sel = 2'd2;
    repeat (4) step();
    chk("up_step2_o",   32'(b0.o),   32'h4);
    chk("up_step2_idx", 32'(b0.idx), 32'h2);

    // One-cycle enable drop, then fresh dwell from sel
    b0.en = 1'b0; b0.sel = 2'd0;
    step();
    chk("endrop_o",    32'(b0.o),    32'h0);
    chk("endrop_idx",  32'(b0.idx),  32'h2);
    chk("endrop_wrap", 32'(b0.wrap), 32'h0);
    b0.en = 1'b1;
    step();
    chk("reentry_o",    32'(b0.o),    32'h1);
    chk("reentry_wrap", 32'(b0.wrap), 32'h0);
    repeat (2) step();
    chk("reentry_dwell_o", 32'(b0.o), 32'h1);
    b0.mode = 1'b0; b0.sel = 2'd1;
    step();
    chk("to_dec_o",    32'(b0.o),    32'h2);
    chk("to_dec_idx",  32'(b0.idx),  32'h1);
    chk("to_dec_wrap", 32'(b0.wrap), 32'h0);

    // Scan down with divide-by-1
    b3.en = 1'b1; b3.mode = 1'b1; b3.dir = 1'b1; b3.sel = 2'd1;
    for (int k = 0; k < 8; k++) begin
      step();
      b3.sel = 2'd0;
      chk("dn_idx",  32'(b3.idx),  32'(idx_seq[k]));
      chk("dn_wrap", 32'(b3.wrap), 32'(wrap_seq[k]));
      e8 = 8'd1 << idx_seq[k];
      chk("dn_o",    32'(b3.o),    32'(e8));
    end
    b3.dir = 1'b0;
    step();
    chk("dirchg_idx",  32'(b3.idx),  32'h3);
    chk("dirchg_wrap", 32'(b3.wrap), 32'h0);
    step();
    chk("dirchg_wrap_idx", 32'(b3.idx),  32'h0);
    chk("dirchg_wrap",     32'(b3.wrap), 32'h1);

    // Mid-scan reset at idx=3, divider=2
    b0.mode = 1'b1; b0.sel = 2'd3; b0.dir = 1'b0;
    repeat (3) step();
    chk("pre_rst_idx", 32'(b0.idx), 32'h3);
    rst_n = 1'b0;
    step();
    chk("midrst_o",    32'(b0.o),    32'h0);
    chk("midrst_idx",  32'(b0.idx),  32'h0);
    chk("midrst_wrap", 32'(b0.wrap), 32'h0);
    step();
    chk("midrst_wrap2", 32'(b0.wrap), 32'h0);
    b0.en = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      step();
      chk("after_rst_wrap", 32'(b0.wrap), 32'h0);
      chk("after_rst_o",    32'(b0.o),    32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/decoder_scan_n.md
Name: decoder_scan_n

Overview:
- Parametrised, registered N-to-2^N line decoder. Successor to the fixed 2-to-4 combinational decoder.
- Adds an output enable, selectable output polarity, and an autonomous scan mode. In scan mode the one-hot output rotates through all lines at a programmable rate.
- Sits between control logic and multiplexed loads, such as display digit selects or bank/row strobes.

Parameters:
- SEL_W, 2, select width N; output width is 2^SEL_W; legal range 1..8.
- SCAN_DIV, 4, clock cycles per scan step; legal range >=1.
- ACTIVE_LOW, 0, output polarity: 0 = asserted line is 1; 1 = asserted line is 0, all others 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- en  input  1  1 = outputs driven; 0 = all lines inactive, block idle.
- mode  input  1  0 = DECODE (follow sel); 1 = SCAN (auto-rotate).
- dir  input  1  scan direction: 0 = index increments; 1 = index decrements.
- sel  input  SEL_W  line index in DECODE; start index on entry to SCAN.
- o  output  2^SEL_W  registered one-hot (or one-cold when ACTIVE_LOW=1) line outputs.
- idx  output  SEL_W  registered index of the currently asserted line.
- wrap  output  1  one-cycle pulse when a scan step wraps around.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, idx=0, wrap=0, divider=0.
  - o = all 0 (ACTIVE_LOW=0) or all 1 (ACTIVE_LOW=1).
  - Reset overrides every other input. Reset during a scan aborts it with no wrap pulse.
- Inactive and active line values:
  - Inactive line value = ACTIVE_LOW.
  - Active line value = ~ACTIVE_LOW.
  - Exactly one line is active in DECODE and SCAN states; none is active in IDLE.
- State machine (IDLE, DECODE, SCAN), evaluated each edge with rst_n=1:
  - en=0 -> IDLE.
  - en=1, mode=0 -> DECODE.
  - en=1, mode=1 -> SCAN.
- IDLE:
  - o all inactive, divider=0, wrap=0.
  - idx holds its last value.
- DECODE:
  - At each edge, idx<=sel and o<=line(sel).
  - Latency: one clock from sel to o and idx.
  - divider=0, wrap=0.
- SCAN entry (previous state not SCAN):
  - idx<=sel, o<=line(sel), divider<=0, wrap<=0.
- SCAN steady state:
  - divider counts 0..SCAN_DIV-1.
  - When divider==SCAN_DIV-1: divider<=0 and idx steps. dir=0 gives idx+1 mod 2^SEL_W; dir=1 gives idx-1 mod 2^SEL_W.
  - o<=line(new idx).
  - Otherwise idx and o hold and divider increments.
  - With SCAN_DIV=1, idx steps on every cycle after entry.
  - Each line stays asserted for exactly SCAN_DIV cycles. The entry line is asserted SCAN_DIV cycles counted from entry.
- wrap:
  - Asserted for exactly the cycle in which o first shows the wrapped index: idx goes max->0 (dir=0) or 0->max (dir=1).
  - Registered alongside o and idx.
- Mid-scan changes:
  - dir changes during SCAN take effect at the next step. No restart; the divider is not cleared.
  - sel changes during SCAN are ignored.
  - SCAN->DECODE: the next edge loads sel; the divider clears.
  - DECODE->SCAN restarts from the current sel.
  - en low for one cycle during SCAN passes through IDLE. Re-entry restarts from sel with divider=0.
- Widths:
  - divider width = clog2(SCAN_DIV), minimum 1 bit.
  - idx arithmetic is modulo 2^SEL_W with no overflow flag other than wrap.
- Output timing: o, idx and wrap are all registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset: SEL_W=2, ACTIVE_LOW=0; hold rst_n=0 for 3 cycles with en=1, mode=0, sel=2 -> o=0000, idx=0, wrap=0. First edge after release -> o=0100, idx=2.
- DECODE sweep: SEL_W=3; sel=0..7 on consecutive cycles -> o=00000001..10000000, each one cycle after its sel. Repeat with ACTIVE_LOW=1 -> o=11111110..01111111.
- SCAN up: SEL_W=2, SCAN_DIV=4, sel=3, en=1, mode=1 -> o=1000 for 4 cycles, then 0001 with wrap=1 for 1 cycle, then 0010 after 4 more cycles.
- SCAN down, SCAN_DIV=1: sel=1, dir=1 -> idx sequence 1,0,3,2,1,0,...; wrap=1 exactly in the cycles where idx=3.
- Mode and enable changes: during SCAN at idx=2, drop en for 1 cycle -> o=0000 for one cycle, then o=line(sel) with a fresh 4-cycle dwell. Switch mode=0 with sel=1 -> o=0010 on the next cycle, wrap=0.
- Mid-scan reset: SCAN at divider=2, idx=3, dir=0; assert rst_n=0 -> o=0000, idx=0, and no wrap pulse in that cycle or afterwards.
